// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory read port, decode handshake and branch redirect.
interface fetch_if #(
  parameter int unsigned PC_W = 32
);
  logic [PC_W-1:0] imem_adr;
  logic [31:0]     imem_ins;
  logic [31:0]     ins;
  logic [PC_W-1:0] ins_pc;
  logic            ins_valid;
  logic            ins_ready;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output imem_adr,
    input  imem_ins,
    output ins,
    output ins_pc,
    output ins_valid,
    input  ins_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  imem_adr,
    output imem_ins,
    input  ins,
    input  ins_pc,
    input  ins_valid,
    output ins_ready,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: PC, 2-entry fetch FIFO, redirect and end-of-program handling.
// Define FETCH_WRAP_EN to make the PC wrap modulo IMEM_DEPTH instead of halting at the end.
module fetch_ctrl #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  fetch_if.master         bus,
  output logic            busy,
  output logic            halted,
  output logic [PC_W-1:0] fetch_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e          state;
  logic [PC_W-1:0] pc;
  logic [1:0]      count;
  logic [31:0]     ins0, ins1;
  logic [PC_W-1:0] pc0, pc1;

  logic            pop;
  logic            fetch_en;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redir_pc;
  logic            redir_halt;
  logic            end_halt;

`ifdef FETCH_WRAP_EN
  localparam logic [PC_W-1:0] PcMask = PC_W'(IMEM_DEPTH - 1);
  assign pc_inc     = (pc + 1'b1) & PcMask;
  assign redir_pc   = bus.redirect_pc & PcMask;
  assign redir_halt = 1'b0;
  assign end_halt   = 1'b0;
`else
  localparam logic [PC_W-1:0] PcLast = PC_W'(IMEM_DEPTH - 1);
  assign pc_inc     = pc + 1'b1;
  assign redir_pc   = bus.redirect_pc;
  assign redir_halt = bus.redirect_pc > PcLast;
  assign end_halt   = pc == PcLast;
`endif

  assign pop      = bus.ins_valid && bus.ins_ready;
  assign fetch_en = (state == StRun) && !bus.redirect && ((count != 2'd2) || pop);

  // Slot 0 is always the FIFO head, so the decode outputs come straight from registers.
  assign bus.imem_adr  = pc;
  assign bus.ins       = ins0;
  assign bus.ins_pc    = pc0;
  assign bus.ins_valid = count != 2'd0;
  assign busy          = state == StRun;
  assign halted        = (state == StHalt) && (count == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      pc          <= '0;
      count       <= 2'd0;
      ins0        <= '0;
      ins1        <= '0;
      pc0         <= '0;
      pc1         <= '0;
      fetch_count <= '0;
    end else if (state == StIdle) begin
      if (start) begin
        state       <= StRun;
        pc          <= '0;
        count       <= 2'd0;
        fetch_count <= '0;
      end
    end else if (bus.redirect) begin
      count <= 2'd0;
      pc    <= redir_pc;
      state <= redir_halt ? StHalt : StRun;
    end else if (fetch_en) begin
      pc <= pc_inc;
      if (fetch_count != '1) fetch_count <= fetch_count + 1'b1;
      if (end_halt) state <= StHalt;
      if (pop && (count == 2'd2)) begin
        ins0 <= ins1;
        pc0  <= pc1;
        ins1 <= bus.imem_ins;
        pc1  <= pc;
      end else if ((count == 2'd0) || pop) begin
        ins0 <= bus.imem_ins;
        pc0  <= pc;
      end else begin
        ins1 <= bus.imem_ins;
        pc1  <= pc;
      end
      if (!pop) count <= count + 2'd1;
    end else if (pop) begin
      ins0  <= ins1;
      pc0   <= pc1;
      count <= count - 2'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a 32-word ROM model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        halted;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_if #(.PC_W(32)) bus ();

  fetch_ctrl #(.IMEM_DEPTH(32), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [4:0] a);
    case (a)
      5'd0:    rom = 32'h0011_0202;
      5'd4:    rom = 32'h0061_8230;
      default: rom = 32'hC0DE_0000 | {27'd0, a};
    endcase
  endfunction

  assign bus.imem_ins = rom(bus.imem_adr[4:0]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.ins_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bus.ins_valid, 0);
    check({tag, "_ins"}, bus.ins, 0);
    check({tag, "_ins_pc"}, bus.ins_pc, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_fcnt"}, fetch_count, 0);
    check({tag, "_adr"}, bus.imem_adr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, then streaming with ins_ready held high.
    do_reset();
    check_reset_outputs("rst");
    bus.ins_ready = 1'b1;
    do_start();
    check("lat_e0_valid", bus.ins_valid, 0);
    check("lat_e0_busy", busy, 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("stream_valid", bus.ins_valid, 1);
      check("stream_pc", bus.ins_pc, k);
      if (k == 0) check("stream_ins0", bus.ins, 32'h0011_0202);
      if (k == 4) check("stream_ins4", bus.ins, 32'h0061_8230);
      tick();
    end

    // Backpressure: two words buffered, pc holds at 2, head stable.
    do_reset();
    do_start();
    tick();
    check("bp_first_valid", bus.ins_valid, 1);
    check("bp_first_pc", bus.ins_pc, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_pc", bus.ins_pc, 0);
      check("bp_hold_ins", bus.ins, 32'h0011_0202);
    end
    check("bp_adr", bus.imem_adr, 2);
    check("bp_fcnt", fetch_count, 2);
    bus.ins_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_release_pc", bus.ins_pc, k);
      tick();
    end
    check("rd_pre_head", bus.ins_pc, 4);
    check("rd_pre_adr", bus.imem_adr, 6);

    // Redirect with a full FIFO at pc 6.
    bus.ins_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd8;
    tick();
    bus.redirect = 1'b0;
    check("rd_c1_valid", bus.ins_valid, 0);
    tick();
    check("rd_c2_valid", bus.ins_valid, 1);
    check("rd_c2_pc", bus.ins_pc, 8);
    check("rd_c2_ins", bus.ins, 32'hC0DE_0008);
    bus.ins_ready = 1'b1;
    tick();
    check("rd_next_pc", bus.ins_pc, 9);

`ifdef FETCH_WRAP_EN
    // Wrap: 31 is followed by 0, redirect target truncated.
    do_reset();
    bus.ins_ready = 1'b1;
    do_start();
    tick();
    for (int k = 0; k < 32; k++) begin
      check("wrap_pc", bus.ins_pc, k);
      tick();
    end
    check("wrap_pc0", bus.ins_pc, 0);
    check("wrap_busy", busy, 1);
    check("wrap_halted", halted, 0);
    tick();
    check("wrap_pc1", bus.ins_pc, 1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd35;
    tick();
    bus.redirect = 1'b0;
    tick();
    check("wrap_rd_valid", bus.ins_valid, 1);
    check("wrap_rd_pc", bus.ins_pc, 3);
    check("wrap_rd_ins", bus.ins, 32'hC0DE_0003);
`else
    // End of memory: halt after word 31, redirect resumes.
    do_reset();
    bus.ins_ready = 1'b1;
    do_start();
    tick();
    for (int k = 0; k < 32; k++) begin
      check("end_pc", bus.ins_pc, k);
      if (k == 31) check("end_busy_last", busy, 0);
      tick();
    end
    check("end_valid", bus.ins_valid, 0);
    check("end_halted", halted, 1);
    check("end_busy", busy, 0);
    check("end_fcnt", fetch_count, 32);
    check("end_adr", bus.imem_adr, 32);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd0;
    tick();
    bus.redirect = 1'b0;
    check("end_rd_busy", busy, 1);
    check("end_rd_halted", halted, 0);
    tick();
    check("end_rd_valid", bus.ins_valid, 1);
    check("end_rd_pc", bus.ins_pc, 0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd40;
    tick();
    bus.redirect = 1'b0;
    check("oor_busy", busy, 0);
    check("oor_valid", bus.ins_valid, 0);
    check("oor_halted", halted, 1);
`endif

    // Reset with two entries buffered; start required again.
    do_reset();
    do_start();
    tick();
    tick();
    check("rstmid_valid_pre", bus.ins_valid, 1);
    check("rstmid_adr_pre", bus.imem_adr, 2);
    rst = 1'b1;
    tick();
    check_reset_outputs("rstmid");
    rst = 1'b0;
    repeat (4) tick();
    check("nostart_valid", bus.ins_valid, 0);
    check("nostart_busy", busy, 0);
    check("nostart_adr", bus.imem_adr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch sequencer for the single-cycle core. It owns the program counter and drives the instruction memory's combinational word-indexed read port. It buffers fetched words in a 2-entry FIFO and hands them to decode over a valid/ready handshake. It also handles branch redirects, such as taken `beq`, and end-of-program termination.

## Interface
Parameters:
- `IMEM_DEPTH`, 32: number of instruction words. Must be a power of two.
- `PC_W`, 32: width of the PC and the address bus.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset. Synchronous and active-high.
- `start`, in, 1: single-cycle pulse that begins fetching from word 0. Only honoured in IDLE.
- `imem_adr`, out, PC_W: word index driven to the instruction memory.
- `imem_ins`, in, 32: instruction word returned combinationally for `imem_adr`.
- `ins`, out, 32: instruction at the FIFO head.
- `ins_pc`, out, PC_W: word index of `ins`.
- `ins_valid`, out, 1: FIFO head is valid.
- `ins_ready`, in, 1: decode accepts the head.
- `redirect`, in, 1: branch taken. Flushes the FIFO and reloads the PC.
- `redirect_pc`, in, PC_W: absolute word index of the branch target.
- `busy`, out, 1: state is RUN.
- `halted`, out, 1: state is HALT and the FIFO is empty.
- `fetch_count`, out, PC_W: number of words pushed since `start`. Saturates at all-ones.

## Operation
State machine (IDLE, RUN, HALT):
- IDLE: `start` loads pc=0, clears the FIFO and `fetch_count`, then moves to RUN. `redirect` is ignored.
- RUN: fetch is enabled whenever `fetch_en` is true.
  - `fetch_en` = RUN && !redirect && (count<2 || pop).
  - pop = ins_valid && ins_ready.
  - On a fetch: push {imem_ins, pc}, set pc <= pc+1, increment `fetch_count`.
- HALT: no fetches. The FIFO continues draining to decode. `redirect` returns the block to RUN.

Outputs and FIFO:
- `imem_adr` = pc in all states.
- FIFO: 2 entries, in-order. Push and pop may occur in the same cycle when full, and count stays at 2.

Redirect (highest priority, in RUN or HALT):
- FIFO cleared. A pop in the same cycle is still a completed handshake, but nothing else survives the flush.
- pc <= redirect_pc.
- No push that cycle.
- State becomes RUN, subject to the range rules under Configuration.

End of memory:
- Behaviour when pc+1 reaches IMEM_DEPTH is set by the configuration macro.

`rst` mid-operation:
- Discards the FIFO contents, returns to IDLE, and forces every output to its reset value on the next edge.

## Timing
Reset values:
- state IDLE, pc 0, FIFO empty.
- `ins_valid` 0, `ins` 0, `ins_pc` 0.
- `busy` 0, `halted` 0, `fetch_count` 0, `imem_adr` 0.

Latency:
- `start` sampled at edge E0.
- At E1, word 0 is pushed.
- `ins_valid`=1 with `ins`=rom[0] in the cycle after E1.
- Start-to-first-valid: 2 cycles.

Throughput:
- 1 instruction per cycle while `ins_ready` is held high.

Backpressure:
- With `ins_ready`=0, at most 2 words are buffered, and then pc holds.
- `ins`/`ins_pc` stay stable while `ins_valid` && !`ins_ready`.

Redirect:
- Asserted in cycle C: `ins_valid`=0 in C+1.
- Target word is valid in C+2.

## Configuration
`FETCH_WRAP_EN`
- Defined:
  - pc increments modulo IMEM_DEPTH, so (IMEM_DEPTH-1)+1 → 0 and the block stays in RUN indefinitely.
  - `redirect_pc` is truncated to log2(IMEM_DEPTH) bits.
  - HALT is reachable only via no path; `halted` stays 0.
- Undefined:
  - After pushing word IMEM_DEPTH-1, the block enters HALT with pc=IMEM_DEPTH.
  - A `redirect_pc` ≥ IMEM_DEPTH flushes the FIFO and enters HALT directly.
  - `halted` rises once the FIFO drains.

## Test plan
- Reset then `start`, `ins_ready`=1 constant: `ins_pc` sequence 0,1,2,… one per cycle. First valid 2 cycles after `start`. `ins`=0x00110202 at pc 0 and 0x00618230 at pc 4.
- `ins_ready`=0 for 5 cycles after the first valid: pc stops at 2, `ins_pc`=0 held stable. Release: 0,1,2 delivered in order with no loss or duplicate.
- `redirect`=1 with `redirect_pc`=8 while at pc 6, FIFO full: next valid is `ins_pc`=8 two cycles later. Words 6/7 never appear.
- Without `FETCH_WRAP_EN`, IMEM_DEPTH=32, run to the end: last `ins_pc`=31, then `busy`=0 and `halted`=1, `fetch_count`=32. A redirect to 0 resumes RUN.
- With `FETCH_WRAP_EN`: `ins_pc` 31 is followed by 0. `redirect_pc`=35 lands on 3.
- `rst` asserted with 2 entries buffered: all outputs at reset values on the next cycle. `start` is required again before any valid.
